// File: rtl/j1_pkg.sv
// rtl/j1_pkg.sv - shared opcode/function codes and parameter legality check for the J1 sequencer
package j1_pkg;

    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_CBR  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_ALU  = 3'b011;

    localparam logic [2:0] FUNC_T_N    = 3'd1;
    localparam logic [2:0] FUNC_T_R    = 3'd2;
    localparam logic [2:0] FUNC_MEM_WR = 3'd3;
    localparam logic [2:0] FUNC_IO_WR  = 3'd4;
    localparam logic [2:0] FUNC_IO_RD  = 3'd5;

    // Jump targets are 13 bits, return addresses come from R[PC_W:1], deltas need 2 bits
    function automatic bit widths_legal(int width, int pc_w, int dsp_w, int rsp_w);
        return (pc_w >= 13) && (width >= pc_w + 1) && (dsp_w >= 2) && (rsp_w >= 2);
    endfunction

endpackage

// File: rtl/j1_sp_track.sv
// rtl/j1_sp_track.sv - stack pointer register with signed 2-bit delta and sticky ovf/unf flags
module j1_sp_track #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flag_en,
    input  logic          flags_clr,
    input  logic [1:0]    delta,
    output logic [PW-1:0] ptr,
    output logic          ovf,
    output logic          unf
);

    logic ovf_ev;
    logic unf_ev;

    // Overflow/underflow events: the pointer is about to wrap past either end
    always_comb begin
        ovf_ev = flag_en && (&ptr) && (delta == 2'b01);
        unf_ev = flag_en && (ptr == '0) && delta[1];
    end

    // Pointer moves on every enabled cycle; a fresh event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (en) begin
            ptr <= ptr + PW'($signed(delta));
            ovf <= ovf_ev | (ovf & ~flags_clr);
            unf <= unf_ev | (unf & ~flags_clr);
        end
    end

endmodule

// File: rtl/j1_seq_ctrl.sv
// rtl/j1_seq_ctrl.sv - J1 instruction sequencer: decode, PC, stack pointers, reboot and strobes
module j1_seq_ctrl
    import j1_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PC_W  = 13,
    parameter int DSP_W = 4,
    parameter int RSP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [15:0]      insn,
    input  logic [WIDTH-1:0] T,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] R,
    input  logic             flags_clr,
    output logic [PC_W-1:0]  pc,
    output logic [DSP_W-1:0] dsp,
    output logic [RSP_W-1:0] rsp,
    output logic             mem_wr,
    output logic             io_wr,
    output logic             io_rd,
    output logic [WIDTH-1:0] dout,
    output logic             dstkW,
    output logic             rstkW,
    output logic [WIDTH-1:0] rstkD,
    output logic             ds_ovf,
    output logic             ds_unf,
    output logic             rs_ovf,
    output logic             rs_unf
);

    if (!widths_legal(WIDTH, PC_W, DSP_W, RSP_W)) begin : g_bad_params
        $error("j1_seq_ctrl: illegal WIDTH/PC_W/DSP_W/RSP_W combination");
    end

    logic            reboot;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_n;
    logic [PC_W-1:0] pc_plus1;
    logic [1:0]      ds_delta;
    logic [1:0]      rs_delta;
    logic [2:0]      op;
    logic [2:0]      func;
    logic            ret_fetch;
    logic            is_lit;
    logic            is_jmp;
    logic            is_cbr;
    logic            is_call;
    logic            is_alu;
    logic            dstk_we;
    logic            rstk_we;
    logic            gate;

    // Only R[PC_W:1] feeds the PC; the remaining bits are deliberately ignored
    logic unused_r;
    assign unused_r = ^R;

    // Decode: classify the instruction, derive stack deltas, strobes and next PC
    always_comb begin
        pc_plus1  = pc_q + PC_W'(1);
        ret_fetch = pc_q[PC_W-1];
        op        = insn[15:13];
        func      = insn[6:4];
        is_lit    = !ret_fetch && insn[15];
        is_jmp    = !ret_fetch && (op == OP_JMP);
        is_cbr    = !ret_fetch && (op == OP_CBR);
        is_call   = !ret_fetch && (op == OP_CALL);
        is_alu    = !ret_fetch && (op == OP_ALU);
        gate      = stall | reboot | reset;

        ds_delta = 2'b00;
        dstk_we  = 1'b0;
        if (ret_fetch || is_lit) begin
            ds_delta = 2'b01;
            dstk_we  = 1'b1;
        end else if (is_cbr) begin
            ds_delta = 2'b11;
        end else if (is_alu) begin
            ds_delta = insn[1:0];
            dstk_we  = (func == FUNC_T_N);
        end

        rs_delta = 2'b00;
        rstk_we  = 1'b0;
        if (ret_fetch) begin
            rs_delta = 2'b11;
        end else if (is_call) begin
            rs_delta = 2'b01;
            rstk_we  = 1'b1;
        end else if (is_alu) begin
            rs_delta = insn[3:2];
            rstk_we  = (func == FUNC_T_R);
        end

        mem_wr = !gate && is_alu && (func == FUNC_MEM_WR);
        io_wr  = !gate && is_alu && (func == FUNC_IO_WR);
        io_rd  = !gate && is_alu && (func == FUNC_IO_RD);
        dstkW  = !gate && dstk_we;
        rstkW  = !gate && rstk_we;
        dout   = N;
        rstkD  = insn[13] ? T : WIDTH'({pc_plus1, 1'b0});

        if (reboot) begin
            pc_n = '0;
        end else if (is_jmp || is_call || (is_cbr && (T == '0))) begin
            pc_n = PC_W'(insn[12:0]);
        end else if (ret_fetch || (is_alu && insn[7])) begin
            pc_n = R[PC_W:1];
        end else begin
            pc_n = pc_plus1;
        end
    end

    // PC and reboot register; stall freezes both
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q   <= '0;
            reboot <= 1'b1;
        end else if (!stall) begin
            pc_q   <= pc_n;
            reboot <= 1'b0;
        end
    end

    assign pc = pc_q;

    j1_sp_track #(.PW(DSP_W)) u_ds (
        .clk       (clk),
        .reset     (reset),
        .en        (!stall),
        .flag_en   (!stall && !reboot),
        .flags_clr (flags_clr),
        .delta     (ds_delta),
        .ptr       (dsp),
        .ovf       (ds_ovf),
        .unf       (ds_unf)
    );

    j1_sp_track #(.PW(RSP_W)) u_rs (
        .clk       (clk),
        .reset     (reset),
        .en        (!stall),
        .flag_en   (!stall && !reboot),
        .flags_clr (flags_clr),
        .delta     (rs_delta),
        .ptr       (rsp),
        .ovf       (rs_ovf),
        .unf       (rs_unf)
    );

endmodule
